fpu_normalizer: RTL and testbench



---
 rtl/fpu_normalizer.sv | 151 +++++++++++++++
 tb/tb_fpu_normalizer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_normalizer.sv
// rtl/fpu_normalizer.sv - post-ALU normalize, round-to-nearest-even and single-precision pack stage
// Subnormal support is enabled by defining FPU_NORM_SUBNORMAL_EN; the default build flushes to zero.
module fpu_normalizer #(
  parameter int EXP_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign_in,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [27:0]      mant_in,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result,
  output logic             ovf,
  output logic             unf
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, PACK} state_t;

  localparam logic signed [EXP_W-1:0] E_ONE = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] E_MAX = EXP_W'(255);

  state_t                  state_q;
  logic [27:0]             m_q;
  logic signed [EXP_W-1:0] e_q;
  logic                    s_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    ovf_q;
  logic                    unf_q;
  logic [31:0]             result_q;
`ifndef FPU_NORM_SUBNORMAL_EN
  logic                    flush_q;
`endif

  logic [27:0]             m_shr;
  logic [27:0]             m_shl;
  logic signed [EXP_W-1:0] e_inc;
  logic signed [EXP_W-1:0] e_dec;
  logic                    rnd_up;
  logic [24:0]             rnd_sum;
  logic [27:0]             m_rnd;
  logic [27:0]             m_rnd_shr;

  // Right shifts keep the dropped bit alive in the sticky position.
  assign m_shr     = {1'b0, m_q[27:2], m_q[1] | m_q[0]};
  assign m_shl     = {m_q[26:0], 1'b0};
  assign e_inc     = e_q + E_ONE;
  assign e_dec     = e_q - E_ONE;
  assign rnd_up    = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
  assign rnd_sum   = {1'b0, m_q[26:3]} + {24'h0, rnd_up};
  assign m_rnd     = {rnd_sum, m_q[2:0]};
  assign m_rnd_shr = {1'b0, m_rnd[27:2], m_rnd[1] | m_rnd[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      m_q      <= '0;
      e_q      <= '0;
      s_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      result_q <= '0;
`ifndef FPU_NORM_SUBNORMAL_EN
      flush_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            s_q     <= sign_in;
            e_q     <= exp_in;
            m_q     <= mant_in;
            busy_q  <= 1'b1;
            state_q <= NORM;
`ifndef FPU_NORM_SUBNORMAL_EN
            flush_q <= 1'b0;
`endif
          end
        end
        NORM: begin
          if (m_q == '0) begin
            state_q <= PACK;
          end else if (m_q[27]) begin
            m_q <= m_shr;
            e_q <= e_inc;
`ifdef FPU_NORM_SUBNORMAL_EN
          end else if (e_q < E_ONE) begin
            m_q <= m_shr;
            e_q <= e_inc;
`endif
          end else if (!m_q[26] && (e_q > E_ONE)) begin
            m_q <= m_shl;
            e_q <= e_dec;
          end else begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          // A carry out of the rounded mantissa renormalizes in the same cycle.
          if (rnd_sum[24]) begin
            m_q <= m_rnd_shr;
            e_q <= e_inc;
          end else begin
            m_q <= m_rnd;
          end
`ifndef FPU_NORM_SUBNORMAL_EN
          flush_q <= (e_q < E_ONE);
`endif
          state_q <= PACK;
        end
        PACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          ovf_q   <= 1'b0;
          unf_q   <= 1'b0;
          if (e_q >= E_MAX) begin
            result_q <= {s_q, 8'hFF, 23'h0};
            ovf_q    <= 1'b1;
          end else if (m_q == '0) begin
            result_q <= {s_q, 31'h0};
`ifdef FPU_NORM_SUBNORMAL_EN
          end else if (!m_q[26]) begin
            result_q <= {s_q, 8'h00, m_q[25:3]};
            unf_q    <= 1'b1;
`else
          end else if (!m_q[26] || flush_q) begin
            result_q <= {s_q, 31'h0};
            unf_q    <= 1'b1;
`endif
          end else begin
            result_q <= {s_q, e_q[7:0], m_q[25:3]};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;

endmodule

// File: tb/tb_fpu_normalizer.sv
// tb/tb_fpu_normalizer.sv - self-checking bench for fpu_normalizer (vector table, corner sequences, random vs model)
// Honors FPU_NORM_SUBNORMAL_EN to select the matching expectations.
module tb_fpu_normalizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sign_in = 1'b0;
  logic [9:0]  exp_in = '0;
  logic [27:0] mant_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        ovf;
  logic        unf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fpu_normalizer #(.EXP_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .sign_in(sign_in), .exp_in(exp_in),
    .mant_in(mant_in), .busy(busy), .done(done), .result(result), .ovf(ovf), .unf(unf)
  );

  typedef struct {
    logic        s;
    logic [9:0]  e;
    logic [27:0] m;
    logic [31:0] r;
    logic        o;
    logic        u;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: value-level normalize / round / pack with integer arithmetic.
  function automatic void model(input logic s, input logic [9:0] ein, input logic [27:0] min,
                                output logic [31:0] res, output logic o, output logic u,
                                output int lat);
    longint m;
    longint q;
    int     e;
    int     pre_e;
    int     shifts;
    m = longint'(min);
    e = int'($signed(ein));
    shifts = 0;
    o = 1'b0;
    u = 1'b0;
    if (min == 28'h0) begin
      lat = 3;
      if (e >= 255) begin
        res = {s, 8'hFF, 23'h0};
        o = 1'b1;
      end else begin
        res = {s, 31'h0};
      end
      return;
    end
    if (m >= (longint'(1) << 27)) begin
      m = (m >> 1) | (m & 1);
      e++;
      shifts++;
    end
`ifdef FPU_NORM_SUBNORMAL_EN
    while (e < 1) begin
      m = (m >> 1) | (m & 1);
      e++;
      shifts++;
    end
`endif
    while (m < (longint'(1) << 26) && e > 1) begin
      m = m * 2;
      e--;
      shifts++;
    end
    lat = 4 + shifts;
    pre_e = e;
    q = m >> 3;
    if (m[2] && (m[1] || m[0] || m[3])) q++;
    if (q >= (longint'(1) << 24)) begin
      q = q / 2;
      e++;
    end
    if (e >= 255) begin
      res = {s, 8'hFF, 23'h0};
      o = 1'b1;
`ifdef FPU_NORM_SUBNORMAL_EN
    end else if (q < (longint'(1) << 23)) begin
      res = {s, 8'h00, q[22:0]};
      u = 1'b1;
`else
    end else if (pre_e < 1 || q < (longint'(1) << 23)) begin
      res = {s, 31'h0};
      u = 1'b1;
`endif
    end else begin
      res = {s, e[7:0], q[22:0]};
    end
  endfunction

  // Presents one operand with a single-cycle start and waits (bounded) for done.
  task automatic run_op(input bit now, input logic s, input logic [9:0] e, input logic [27:0] m,
                        output logic [31:0] r, output logic o, output logic u, output int lat);
    if (!now) @(negedge clk);
    sign_in = s;
    exp_in  = e;
    mant_in = m;
    start   = 1'b1;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    r = result;
    o = ovf;
    u = unf;
  endtask

  initial begin
    vec_t        tbl[12];
    logic [31:0] r;
    logic [31:0] r_exp;
    logic        o;
    logic        u;
    logic        o_exp;
    logic        u_exp;
    int          lat;
    int          lat_exp;
    int          n_done;

    tbl[0]  = '{1'b0, 10'd127, 28'h4000000, 32'h3F800000, 1'b0, 1'b0, 4};
    tbl[1]  = '{1'b0, 10'd127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 5};
    tbl[2]  = '{1'b0, 10'd130, 28'h0800000, 32'h3F800000, 1'b0, 1'b0, 7};
    tbl[3]  = '{1'b0, 10'd127, 28'h4000004, 32'h3F800000, 1'b0, 1'b0, 4};
    tbl[4]  = '{1'b0, 10'd127, 28'h400000C, 32'h3F800002, 1'b0, 1'b0, 4};
    tbl[5]  = '{1'b0, 10'd127, 28'h7FFFFFC, 32'h40000000, 1'b0, 1'b0, 4};
    tbl[6]  = '{1'b0, 10'd254, 28'h8000000, 32'h7F800000, 1'b1, 1'b0, 5};
    tbl[7]  = '{1'b1, 10'd127, 28'h0000000, 32'h80000000, 1'b0, 1'b0, 3};
    tbl[8]  = '{1'b0, 10'd153, 28'h0000001, 32'h3F800000, 1'b0, 1'b0, 30};
    tbl[9]  = '{1'b1, 10'd128, 28'h4000000, 32'hC0000000, 1'b0, 1'b0, 4};
`ifdef FPU_NORM_SUBNORMAL_EN
    tbl[10] = '{1'b0, 10'h3FF, 28'h4000000, 32'h00200000, 1'b0, 1'b1, 6};
    tbl[11] = '{1'b0, 10'd1,   28'h2000000, 32'h00400000, 1'b0, 1'b1, 4};
`else
    tbl[10] = '{1'b0, 10'h3FF, 28'h4000000, 32'h00000000, 1'b0, 1'b1, 4};
    tbl[11] = '{1'b0, 10'd1,   28'h2000000, 32'h00000000, 1'b0, 1'b1, 4};
`endif

    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_flags", {30'h0, ovf, unf}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(1'b0, tbl[i].s, tbl[i].e, tbl[i].m, r, o, u, lat);
      check($sformatf("vec%0d_result", i), r, tbl[i].r);
      check($sformatf("vec%0d_ovf", i), {31'h0, o}, {31'h0, tbl[i].o});
      check($sformatf("vec%0d_unf", i), {31'h0, u}, {31'h0, tbl[i].u});
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
    end

    // Outputs hold after the done pulse.
    run_op(1'b0, 1'b0, 10'd127, 28'h400000C, r, o, u, lat);
    check("done_busy_low", {31'h0, busy}, 32'h0);
    @(negedge clk);
    check("hold_result", result, 32'h3F800002);
    check("hold_done_low", {31'h0, done}, 32'h0);

    // New start accepted in the done cycle.
    run_op(1'b0, 1'b0, 10'd127, 28'h4000000, r, o, u, lat);
    run_op(1'b1, 1'b0, 10'd127, 28'h7FFFFFC, r, o, u, lat);
    check("b2b_result", r, 32'h40000000);
    check("b2b_latency", 32'(lat), 32'd4);

    // Start pulses while busy are ignored.
    @(negedge clk);
    sign_in = 1'b0; exp_in = 10'd130; mant_in = 28'h0800000; start = 1'b1;
    @(negedge clk);
    sign_in = 1'b1; exp_in = 10'd127; mant_in = 28'h8000000; start = 1'b1;
    lat = -1;
    for (int k = 2; k <= 100; k++) begin
      @(negedge clk);
      start = (k == 3);
      if (done) begin
        lat = k;
        break;
      end
    end
    check("busy_start_result", result, 32'h3F800000);
    check("busy_start_latency", 32'(lat), 32'd7);
    n_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("busy_start_no_second_done", 32'(n_done), 32'd0);

    // Reset in the middle of a 20-shift normalization.
    @(negedge clk);
    sign_in = 1'b0; exp_in = 10'd200; mant_in = 28'h0000040; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_done", {31'h0, done}, 32'h0);
    check("midrst_result", result, 32'h0);
    reset = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);
    run_op(1'b0, 1'b0, 10'd200, 28'h0000040, r, o, u, lat);
    model(1'b0, 10'd200, 28'h0000040, r_exp, o_exp, u_exp, lat_exp);
    check("after_rst_result", r, r_exp);
    check("after_rst_latency", 32'(lat), 32'(lat_exp));

    for (int i = 0; i < 300; i++) begin
      logic        s;
      logic [9:0]  e;
      logic [27:0] m;
      int          lz;
      s  = 1'($urandom);
      lz = int'($urandom_range(0, 28));
      m  = 28'($urandom) >> lz;
      e  = 10'(int'($urandom_range(0, 340)) - 40);
      model(s, e, m, r_exp, o_exp, u_exp, lat_exp);
      run_op(1'b0, s, e, m, r, o, u, lat);
      check($sformatf("rnd%0d_result", i), r, r_exp);
      check($sformatf("rnd%0d_ovf", i), {31'h0, o}, {31'h0, o_exp});
      check($sformatf("rnd%0d_unf", i), {31'h0, u}, {31'h0, u_exp});
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(lat_exp));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
